// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU.
// It produces one quotient bit per clock, MSB first, and fixes up the signs at the end.
// The result is {remainder, quotient}. ready_o holds until the requester drops start_i.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_e;

    state_e              state_q;
    logic [5:0]          cnt_q;
    logic                signed_q;
    logic                dvdNeg_q;
    logic                dvsNeg_q;
    logic [DATA_W-1:0]   divisor_q;
    logic [DATA_W:0]     partRem_q;
    logic [DATA_W-1:0]   quoShift_q;
    logic [2*DATA_W-1:0] result_q;
    logic                ready_q;

    logic [DATA_W-1:0]   dvdMag;
    logic [DATA_W-1:0]   dvsMag;
    logic [DATA_W:0]     shiftRem;
    logic [DATA_W:0]     trialDiff;
    logic [DATA_W-1:0]   quoFinal;
    logic [DATA_W-1:0]   remFinal;

    // Operand magnitudes at acceptance, trial subtraction for one step, and final sign fix-up.
    always_comb begin
        dvdMag    = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        dvsMag    = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
        shiftRem  = {partRem_q[DATA_W-1:0], quoShift_q[DATA_W-1]};
        trialDiff = shiftRem - {1'b0, divisor_q};
        quoFinal  = (signed_q && (dvdNeg_q ^ dvsNeg_q)) ? (~quoShift_q + 1'b1) : quoShift_q;
        remFinal  = (signed_q && dvdNeg_q) ? (~partRem_q[DATA_W-1:0] + 1'b1)
                                           : partRem_q[DATA_W-1:0];
    end

    // Divider state machine with registered result and ready; annul beats every other transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            dvdNeg_q   <= 1'b0;
            dvsNeg_q   <= 1'b0;
            divisor_q  <= '0;
            partRem_q  <= '0;
            quoShift_q <= '0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    if (start_i && !annul_i) begin
                        signed_q   <= signed_div_i;
                        dvdNeg_q   <= signed_div_i & opdata1_i[DATA_W-1];
                        dvsNeg_q   <= signed_div_i & opdata2_i[DATA_W-1];
                        divisor_q  <= dvsMag;
                        quoShift_q <= dvdMag;
                        partRem_q  <= '0;
                        cnt_q      <= '0;
                        if (opdata2_i == '0) begin
                            state_q <= BYZERO;
                        end else begin
                            state_q <= ON;
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state_q  <= FREE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end else begin
                        state_q  <= END;
                        result_q <= '0;
                        ready_q  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state_q  <= FREE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end else if (cnt_q == 6'd32) begin
                        state_q  <= END;
                        result_q <= {remFinal, quoFinal};
                        ready_q  <= 1'b1;
                    end else begin
                        if (!trialDiff[DATA_W]) begin
                            partRem_q  <= trialDiff;
                            quoShift_q <= {quoShift_q[DATA_W-2:0], 1'b1};
                        end else begin
                            partRem_q  <= shiftRem;
                            quoShift_q <= {quoShift_q[DATA_W-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        state_q  <= FREE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= FREE;
                    result_q <= '0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table vectors, randomized operations against an arithmetic model,
// and hand-written annul / async reset / operand-change sequences.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total;
    int bad;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[9];

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: plain language arithmetic, {remainder, quotient}.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Record one comparison.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one operation with start held; optionally scribble on the inputs mid-flight.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] exp, input string tag, input int mutateAt);
        int lat;
        int expLat;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        expLat       = (b == 32'd0) ? 1 : 33;
        lat          = 0;
        tick();
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == mutateAt) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " result"}, result_o, exp);
        start_i = 1'b0;
        tick();
        checkOutput({tag, " drop ready"}, 64'(ready_o), 64'd0);
        checkOutput({tag, " drop result"}, result_o, 64'd0);
    endtask

    // Main test sequence.
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        seen;
        total = 0;
        bad   = 0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}};
        vecs[3] = '{1'b1, 32'd5,          32'd0,          64'd0};
        vecs[4] = '{1'b0, 32'd5,          32'd0,          64'd0};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}};
        vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0000_0000}};
        vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0000_0000, 32'hFFFF_FFFF}};
        vecs[8] = '{1'b0, 32'd20,         32'd3,          {32'd2, 32'd6}};

        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) tick();
        checkOutput("reset ready", 64'(ready_o), 64'd0);
        checkOutput("reset result", result_o, 64'd0);
        #3 rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), -1);
        end

        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 20);
                2: rb = 32'hFFFF_FFFF - $urandom_range(0, 5);
                default: rb = (i % 8 == 3) ? 32'd0 : $urandom_range(1, 65535);
            endcase
            applyStimulus(rs, ra, rb, refDiv(rs, ra, rb), $sformatf("rand%0d", i), -1);
        end

        applyStimulus(1'b0, 32'd1000, 32'd9, refDiv(1'b0, 32'd1000, 32'd9), "mutate", 5);

        // Annul after 10 ON cycles.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick();
        repeat (10) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        checkOutput("annul ready", 64'(ready_o), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        checkOutput("annul ready quiet", 64'(seen), 64'd0);
        applyStimulus(1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, "after annul", -1);

        // Annul while holding the result in END, start still high.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        tick();
        seen = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (ready_o) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("end annul pre ready", 64'(seen), 64'd1);
        checkOutput("end annul pre result", result_o, {32'd0, 32'd10});
        annul_i = 1'b1;
        tick();
        checkOutput("end annul ready", 64'(ready_o), 64'd0);
        checkOutput("end annul result", result_o, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();

        // Asynchronous reset during ON.
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFF_FF00;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick();
        repeat (5) tick();
        #2 rst = 1'b0;
        start_i = 1'b0;
        #1;
        checkOutput("rst on ready", 64'(ready_o), 64'd0);
        checkOutput("rst on result", result_o, 64'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        applyStimulus(1'b0, 32'd77, 32'd10, {32'd7, 32'd7}, "after rst on", -1);

        // Asynchronous reset while the result is held.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd9;
        opdata2_i    = 32'd2;
        start_i      = 1'b1;
        tick();
        seen = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (ready_o) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("rst end pre result", result_o, {32'd1, 32'd4});
        #2 rst = 1'b0;
        #1;
        checkOutput("rst end ready", 64'(ready_o), 64'd0);
        checkOutput("rst end result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, refDiv(1'b1, 32'hFFFF_FF9C, 32'd7), "after rst end", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
